// File: rtl/fb_sched_pkg.sv
// Shared constants and FSM state type for the framebuffer write scheduler.
package fb_sched_pkg;
   localparam int unsigned FB_COORD_W = 6;
   localparam int unsigned FB_DATA_W  = 8;
   localparam int unsigned REQ_PAINT  = 0;
   localparam int unsigned REQ_AUX    = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_CLEAR = 2'd2
   } fb_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: the pointer names the requester preferred on a tie.
module rr_arbiter2
   import fb_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rstn,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant
);
   logic ptr;

   always_comb begin
      grant = '0;
      if (en) begin
         if (valid == 2'b11) grant[ptr] = 1'b1;
         else                grant      = valid;
      end
   end

   // Grant implies accept, so the pointer moves to the other requester.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        ptr <= 1'b0;
      else if (|grant)  ptr <= ~grant[REQ_AUX];
   end
endmodule

// File: rtl/fb_write_scheduler.sv
// Framebuffer write-port owner: round-robin requester writes plus a full-frame clear sweep.
module fb_write_scheduler
   import fb_sched_pkg::*;
#(
   parameter int unsigned COORD_W  = FB_COORD_W,
   parameter int unsigned DATA_W   = FB_DATA_W,
   parameter int unsigned NUM_COLS = 64,
   parameter int unsigned NUM_ROWS = 64,
   parameter int unsigned WR_GAP   = 1
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [COORD_W-1:0] req0_x,
   input  logic [COORD_W-1:0] req0_y,
   input  logic [DATA_W-1:0]  req0_px,
   input  logic               req0_pal,
   input  logic               req0_ovl,
   input  logic [COORD_W-1:0] req1_x,
   input  logic [COORD_W-1:0] req1_y,
   input  logic [DATA_W-1:0]  req1_px,
   input  logic               req1_pal,
   input  logic               req1_ovl,
   input  logic               clear_start,
   input  logic [DATA_W-1:0]  clear_color,
   output logic               clear_busy,
   output logic [COORD_W-1:0] gpu_column,
   output logic [COORD_W-1:0] gpu_row,
   output logic               gpu_write,
   output logic [DATA_W-1:0]  gpu_px_data,
   output logic               gpu_palette,
   output logic               gpu_overlay
);
   localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(NUM_COLS - 1);
   localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(NUM_ROWS - 1);
   localparam logic [3:0]         GAP_LD   = 4'(WR_GAP);

   fb_state_e          state;
   logic [3:0]         gap_cnt;
   logic               clr_pend;
   logic               clr_last;
   logic [DATA_W-1:0]  clr_color;
   logic [COORD_W-1:0] clr_col;
   logic [COORD_W-1:0] clr_row;
   logic               arb_en;
   logic [1:0]         grant;
   logic               gsel;

   // A clear_start in the same cycle wins over requests, so it also blocks the arbiter.
   assign arb_en    = (state == ST_IDLE) && (gap_cnt == '0) && !clr_pend && !clear_start;
   assign req_ready = grant;
   assign gsel      = grant[REQ_AUX];

   rr_arbiter2 u_arb (
      .clk   (clk),
      .rstn  (rstn),
      .en    (arb_en),
      .valid (req_valid),
      .grant (grant)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_IDLE;
         gap_cnt     <= '0;
         clr_pend    <= 1'b0;
         clr_last    <= 1'b0;
         clr_color   <= '0;
         clr_col     <= '0;
         clr_row     <= '0;
         clear_busy  <= 1'b0;
         gpu_column  <= '0;
         gpu_row     <= '0;
         gpu_write   <= 1'b0;
         gpu_px_data <= '0;
         gpu_palette <= 1'b0;
         gpu_overlay <= 1'b0;
      end else begin
         gpu_write <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 4'd1;
                  if (clear_start && !clr_pend) begin
                     clr_pend  <= 1'b1;
                     clr_color <= clear_color;
                  end
               end else if (clr_pend || clear_start) begin
                  state      <= ST_CLEAR;
                  clear_busy <= 1'b1;
                  clr_pend   <= 1'b0;
                  clr_last   <= 1'b0;
                  clr_col    <= '0;
                  clr_row    <= '0;
                  if (!clr_pend) clr_color <= clear_color;
               end else if (|grant) begin
                  state       <= ST_WRITE;
                  gpu_write   <= 1'b1;
                  gpu_column  <= gsel ? req1_x   : req0_x;
                  gpu_row     <= gsel ? req1_y   : req0_y;
                  gpu_px_data <= gsel ? req1_px  : req0_px;
                  gpu_palette <= gsel ? req1_pal : req0_pal;
                  gpu_overlay <= gsel ? req1_ovl : req0_ovl;
               end
            end
            ST_WRITE: begin
               state   <= ST_IDLE;
               gap_cnt <= GAP_LD;
               if (clear_start && !clr_pend) begin
                  clr_pend  <= 1'b1;
                  clr_color <= clear_color;
               end
            end
            ST_CLEAR: begin
               // Stay in CLEAR through the last strobe so clear_busy covers it.
               if (clr_last) begin
                  state      <= ST_IDLE;
                  clear_busy <= 1'b0;
                  clr_last   <= 1'b0;
                  if (gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
               end else if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else begin
                  gpu_write   <= 1'b1;
                  gpu_column  <= clr_col;
                  gpu_row     <= clr_row;
                  gpu_px_data <= clr_color;
                  gpu_palette <= 1'b0;
                  gpu_overlay <= 1'b0;
                  gap_cnt     <= GAP_LD;
                  if (clr_col == COL_LAST) begin
                     clr_col <= '0;
                     if (clr_row == ROW_LAST) begin
                        clr_row  <= '0;
                        clr_last <= 1'b1;
                     end else begin
                        clr_row <= clr_row + COORD_W'(1);
                     end
                  end else begin
                     clr_col <= clr_col + COORD_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler: directed scenarios plus random traffic against a timeline model.
module tb_fb_write_scheduler;
   localparam int CW  = 6;
   localparam int DW  = 8;
   localparam int NC  = 4;
   localparam int NR  = 4;
   localparam int GAP = 1;

   typedef struct {
      int            c;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
      logic [DW-1:0] px;
      logic          pal;
      logic          ovl;
   } wr_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b1;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_ready;
   logic [CW-1:0] rx [2];
   logic [CW-1:0] ry [2];
   logic [DW-1:0] rpx [2];
   logic          rpal [2];
   logic          rovl [2];
   logic          clear_start = 1'b0;
   logic [DW-1:0] clear_color = '0;
   logic          clear_busy;
   logic [CW-1:0] gpu_column;
   logic [CW-1:0] gpu_row;
   logic          gpu_write;
   logic [DW-1:0] gpu_px_data;
   logic          gpu_palette;
   logic          gpu_overlay;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference timeline: expected strobes by cycle, earliest free cycle, clear window.
   wr_t           q[$];
   int            cyc, free_at, pref, busy_lo, busy_hi, lastg;
   bit            pend;
   logic [DW-1:0] pend_col;
   logic [CW-1:0] h_x, h_y;
   logic [DW-1:0] h_px;
   logic          h_pal, h_ovl;

   fb_write_scheduler #(
      .COORD_W (CW), .DATA_W (DW), .NUM_COLS (NC), .NUM_ROWS (NR), .WR_GAP (GAP)
   ) dut (
      .clk (clk), .rstn (rstn), .req_valid (req_valid), .req_ready (req_ready),
      .req0_x (rx[0]), .req0_y (ry[0]), .req0_px (rpx[0]), .req0_pal (rpal[0]), .req0_ovl (rovl[0]),
      .req1_x (rx[1]), .req1_y (ry[1]), .req1_px (rpx[1]), .req1_pal (rpal[1]), .req1_ovl (rovl[1]),
      .clear_start (clear_start), .clear_color (clear_color), .clear_busy (clear_busy),
      .gpu_column (gpu_column), .gpu_row (gpu_row), .gpu_write (gpu_write),
      .gpu_px_data (gpu_px_data), .gpu_palette (gpu_palette), .gpu_overlay (gpu_overlay)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_wr(input int c, input logic [CW-1:0] x, input logic [CW-1:0] y,
                          input logic [DW-1:0] px, input logic pal, input logic ovl);
      wr_t w;
      w.c = c; w.x = x; w.y = y; w.px = px; w.pal = pal; w.ovl = ovl;
      q.push_back(w);
   endtask

   // Clear accepted in cycle cyc: one strobe every 1+GAP cycles starting two cycles later.
   task automatic start_clear(input logic [DW-1:0] color);
      int k = 0;
      for (int r = 0; r < NR; r++)
         for (int c = 0; c < NC; c++) begin
            push_wr(cyc + 2 + k * (1 + GAP), CW'(c), CW'(r), color, 1'b0, 1'b0);
            k++;
         end
      busy_lo = cyc + 1;
      busy_hi = cyc + 2 + (NC * NR - 1) * (1 + GAP);
      free_at = busy_hi + ((GAP > 0) ? GAP : 1);
   endtask

   task automatic tick();
      logic [1:0] er;
      int         g;
      bit         in_clr, ew;
      wr_t        w;
      @(negedge clk);
      in_clr = (cyc >= busy_lo) && (cyc <= busy_hi);
      er = '0;
      g  = -1;
      if (!in_clr && cyc >= free_at && !pend && !clear_start && req_valid != 2'b00) begin
         g = (req_valid == 2'b11) ? pref : (req_valid[1] ? 1 : 0);
         er[g] = 1'b1;
      end
      chk("req_ready", {30'd0, req_ready}, {30'd0, er});
      ew = 1'b0;
      if (q.size() > 0 && q[0].c == cyc) begin
         w = q.pop_front();
         ew = 1'b1;
         h_x = w.x; h_y = w.y; h_px = w.px; h_pal = w.pal; h_ovl = w.ovl;
      end
      chk("gpu_write", {31'd0, gpu_write}, {31'd0, ew});
      chk("gpu_column", {26'd0, gpu_column}, {26'd0, h_x});
      chk("gpu_row", {26'd0, gpu_row}, {26'd0, h_y});
      chk("gpu_px_data", {24'd0, gpu_px_data}, {24'd0, h_px});
      chk("gpu_palette", {31'd0, gpu_palette}, {31'd0, h_pal});
      chk("gpu_overlay", {31'd0, gpu_overlay}, {31'd0, h_ovl});
      chk("clear_busy", {31'd0, clear_busy}, {31'd0, in_clr});
      lastg = g;
      if (g >= 0) begin
         push_wr(cyc + 1, rx[g], ry[g], rpx[g], rpal[g], rovl[g]);
         free_at = cyc + 2 + GAP;
         pref    = 1 - g;
      end else if (!in_clr && (clear_start || pend)) begin
         if (cyc < free_at) begin
            if (!pend) begin
               pend     = 1'b1;
               pend_col = clear_color;
            end
         end else begin
            start_clear(pend ? pend_col : clear_color);
            pend = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      req_valid   = '0;
      clear_start = 1'b0;
      rstn        = 1'b0;
      #1;
      chk("rst_write", {31'd0, gpu_write}, 32'd0);
      chk("rst_column", {26'd0, gpu_column}, 32'd0);
      chk("rst_row", {26'd0, gpu_row}, 32'd0);
      chk("rst_px", {24'd0, gpu_px_data}, 32'd0);
      chk("rst_pal_ovl", {30'd0, gpu_palette, gpu_overlay}, 32'd0);
      chk("rst_busy", {31'd0, clear_busy}, 32'd0);
      chk("rst_ready", {30'd0, req_ready}, 32'd0);
      q.delete();
      cyc = 0; free_at = 0; pref = 0; pend = 1'b0; busy_lo = 1; busy_hi = 0; lastg = -1;
      h_x = '0; h_y = '0; h_px = '0; h_pal = 1'b0; h_ovl = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   // Requesters refresh fields only when idle or just accepted, so pending requests stay stable.
   task automatic drive_random(input int unsigned pct);
      for (int i = 0; i < 2; i++)
         if (lastg == i || !req_valid[i]) begin
            req_valid[i] = ($urandom_range(99) < pct);
            rx[i]   = CW'($urandom);
            ry[i]   = CW'($urandom);
            rpx[i]  = DW'($urandom);
            rpal[i] = 1'($urandom);
            rovl[i] = 1'($urandom);
         end
   endtask

   task automatic run_idle();
      int guard = 0;
      while ((q.size() != 0 || pend || cyc <= busy_hi || req_valid != 2'b00) && guard < 500) begin
         tick();
         if (lastg >= 0) req_valid[lastg] = 1'b0;
         guard++;
      end
      chk("drain_bound", guard, (guard < 500) ? guard : 0);
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         rx[i] = '0; ry[i] = '0; rpx[i] = '0; rpal[i] = 1'b0; rovl[i] = 1'b0;
      end
      do_reset();

      // Single paint write: ready pulse, strobe one cycle later.
      req_valid = 2'b01; rx[0] = 6'd5; ry[0] = 6'd7; rpx[0] = 8'h2A;
      tick();
      req_valid = 2'b00;
      tick();
      run_idle();

      // Both requesters continuously valid.
      req_valid = 2'b11;
      repeat (20) begin
         drive_random(100);
         tick();
      end
      req_valid = 2'b00;
      run_idle();

      // Clear with both requesters stalled behind it.
      clear_color = 8'h00; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      req_valid = 2'b11;
      run_idle();

      // Clear requested in a write's gap, aux waiting throughout.
      req_valid = 2'b01; rx[0] = 6'd63; ry[0] = 6'd40; rpx[0] = 8'hFF; rpal[0] = 1'b1;
      tick();
      req_valid = 2'b10; rx[1] = 6'd9; ry[1] = 6'd3; rpx[1] = 8'h11; rovl[1] = 1'b1;
      tick();
      clear_color = 8'h77; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      run_idle();

      // Reset in the middle of a sweep, then a fresh sweep.
      clear_color = 8'h5A; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      begin
         int guard = 0;
         while (!(q.size() > 0 && q[0].c == cyc && q[0].x == 6'd2 && q[0].y == 6'd1) && guard < 100) begin
            tick();
            guard++;
         end
         chk("mid_clear_bound", guard, (guard < 100) ? guard : 0);
      end
      @(negedge clk);
      chk("mid_clear_write", {31'd0, gpu_write}, 32'd1);
      chk("mid_clear_col", {26'd0, gpu_column}, 32'd2);
      chk("mid_clear_row", {26'd0, gpu_row}, 32'd1);
      do_reset();
      clear_color = 8'hC3; clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      run_idle();

      // Random traffic with occasional clears.
      repeat (600) begin
         drive_random(60);
         clear_start = ($urandom_range(59) == 0);
         clear_color = DW'($urandom);
         tick();
         clear_start = 1'b0;
      end
      req_valid = 2'b00;
      run_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end
endmodule
